// File: rtl/potential_adder_array_if.sv
// Handshake and config bundle for potential_adder_array; the slave modport is the DUT side.
interface potential_adder_array_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 4
);
  logic                    cfg_we;
  logic [IDX_W-1:0]        cfg_idx;
  logic [1:0]              cfg_sel;
  logic signed [WIDTH-1:0] cfg_data;

  logic                    in_valid;
  logic                    in_ready;
  logic [IDX_W-1:0]        in_idx;
  logic signed [WIDTH-1:0] in_weight;
  logic signed [WIDTH-1:0] in_potential;

  logic                    out_valid;
  logic                    out_ready;
  logic [IDX_W-1:0]        out_idx;
  logic signed [WIDTH-1:0] out_potential;
  logic                    out_spike;

  modport master (
    output cfg_we, cfg_idx, cfg_sel, cfg_data,
    output in_valid, in_idx, in_weight, in_potential,
    input  in_ready,
    input  out_valid, out_idx, out_potential, out_spike,
    output out_ready
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_sel, cfg_data,
    input  in_valid, in_idx, in_weight, in_potential,
    output in_ready,
    output out_valid, out_idx, out_potential, out_spike,
    input  out_ready
  );
endinterface

// File: rtl/potential_adder_array.sv
// Time-multiplexed saturating potential adder with per-neuron threshold, reset mode and refractory period.
// Two register stages (accept -> stage 1 -> output); full stall of both stages while out_valid && !out_ready.
module potential_adder_array #(
  parameter int WIDTH    = 32,
  parameter int NEURONS  = 16,
  parameter int IDX_W    = $clog2(NEURONS),
  parameter int REFRAC_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  potential_adder_array_if.slave bus
);

  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [IDX_W-1:0]        idx;
    logic signed [WIDTH-1:0] sum;
    logic signed [WIDTH-1:0] pot;
  } s1_t;

  function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? SMIN : SMAX;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? SMIN : SMAX;
    return s[WIDTH-1:0];
  endfunction

  // Per-neuron state
  logic signed [WIDTH-1:0] thr_q     [NEURONS];
  logic signed [WIDTH-1:0] rst_val_q [NEURONS];
  logic [REFRAC_W-1:0]     per_q     [NEURONS];
  logic [REFRAC_W-1:0]     cnt_q     [NEURONS];
  logic [1:0]              mode_q    [NEURONS];

  logic                    s1_vld;
  s1_t                     s1_q;
  logic                    adv;
  logic                    s1_in_range;
  logic [IDX_W-1:0]        rd_idx;
  logic                    cfg_hit;
  logic signed [WIDTH-1:0] nxt_pot;
  logic                    nxt_spk;
  logic [REFRAC_W-1:0]     nxt_cnt;

  assign adv          = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = adv;

  assign s1_in_range = (32'(s1_q.idx) < NEURONS);
  assign rd_idx      = s1_in_range ? s1_q.idx : '0;
  assign cfg_hit     = bus.cfg_we && (32'(bus.cfg_idx) < NEURONS);

  // Stage 2 evaluation reads state combinationally; the write lands on the same edge as the output.
  always_comb begin
    nxt_pot = s1_q.sum;
    nxt_spk = 1'b0;
    nxt_cnt = cnt_q[rd_idx];
    if (s1_in_range) begin
      if (cnt_q[rd_idx] != '0) begin
        nxt_pot = s1_q.pot;
        nxt_cnt = cnt_q[rd_idx] - 1'b1;
      end else if (s1_q.sum > thr_q[rd_idx]) begin
        nxt_spk = 1'b1;
        nxt_pot = mode_q[rd_idx][0] ? rst_val_q[rd_idx] : sat_sub(s1_q.sum, thr_q[rd_idx]);
        nxt_cnt = per_q[rd_idx];
      end else if (mode_q[rd_idx][1] && s1_q.sum[WIDTH-1]) begin
        nxt_pot = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld            <= 1'b0;
      s1_q              <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_idx       <= '0;
      bus.out_potential <= '0;
      bus.out_spike     <= 1'b0;
      for (int i = 0; i < NEURONS; i++) begin
        thr_q[i]     <= '0;
        rst_val_q[i] <= '0;
        per_q[i]     <= '0;
        cnt_q[i]     <= '0;
        mode_q[i]    <= '0;
      end
    end else begin
      if (adv) begin
        s1_vld <= bus.in_valid;
        if (bus.in_valid) begin
          s1_q.idx <= bus.in_idx;
          s1_q.sum <= sat_add(bus.in_weight, bus.in_potential);
          s1_q.pot <= bus.in_potential;
        end
        bus.out_valid <= s1_vld;
        if (s1_vld) begin
          bus.out_idx       <= s1_q.idx;
          bus.out_potential <= nxt_pot;
          bus.out_spike     <= nxt_spk;
          if (s1_in_range) cnt_q[rd_idx] <= nxt_cnt;
        end
      end
      // Placed after the evaluation write so a same-cycle period write owns refrac_cnt.
      if (cfg_hit) begin
        case (bus.cfg_sel)
          2'd0: thr_q[bus.cfg_idx]     <= bus.cfg_data;
          2'd1: rst_val_q[bus.cfg_idx] <= bus.cfg_data;
          2'd2: begin
            per_q[bus.cfg_idx] <= bus.cfg_data[REFRAC_W-1:0];
            cnt_q[bus.cfg_idx] <= '0;
          end
          default: mode_q[bus.cfg_idx] <= bus.cfg_data[1:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_potential_adder_array.sv
// Directed self-checking bench for potential_adder_array (12 neurons so out-of-range indices exist).
module tb_potential_adder_array;
  localparam int WIDTH    = 32;
  localparam int NEURONS  = 12;
  localparam int IDX_W    = 4;
  localparam int REFRAC_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  potential_adder_array_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  potential_adder_array #(
    .WIDTH(WIDTH), .NEURONS(NEURONS), .IDX_W(IDX_W), .REFRAC_W(REFRAC_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [IDX_W-1:0] idx, input logic [1:0] sel,
                     input logic signed [WIDTH-1:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = idx;
    bus.cfg_sel  = sel;
    bus.cfg_data = data;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  // Drive one beat and check the result appears exactly two edges later.
  task automatic beat(input string tag, input logic [IDX_W-1:0] idx,
                      input logic signed [WIDTH-1:0] w, input logic signed [WIDTH-1:0] p,
                      input logic signed [WIDTH-1:0] exp_pot, input logic exp_spk);
    bus.out_ready    = 1'b1;
    bus.in_valid     = 1'b1;
    bus.in_idx       = idx;
    bus.in_weight    = w;
    bus.in_potential = p;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk({tag, "_vld"}, 64'(bus.out_valid), 64'(1'b1));
    chk({tag, "_idx"}, 64'(bus.out_idx), 64'(idx));
    chk({tag, "_pot"}, bus.out_potential, exp_pot);
    chk({tag, "_spk"}, 64'(bus.out_spike), 64'(exp_spk));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    int  got;
    int  cyc;
    int  stray;
    bit  acc;

    bus.cfg_we       = 1'b0;
    bus.cfg_idx      = '0;
    bus.cfg_sel      = '0;
    bus.cfg_data     = '0;
    bus.in_valid     = 1'b0;
    bus.in_idx       = '0;
    bus.in_weight    = '0;
    bus.in_potential = '0;
    bus.out_ready    = 1'b1;

    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("rst_out_pot", bus.out_potential, 64'(0));
    chk("rst_out_spike", 64'(bus.out_spike), 64'(1'b0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
    #10 rst_n = 1'b1;
    tick();

    cfg(3, 2'd0, 100);
    beat("add", 3, 40, 50, 90, 1'b0);

    cfg(0, 2'd0, 100);
    beat("sub", 0, 70, 60, 30, 1'b1);

    cfg(1, 2'd0, 100);
    cfg(1, 2'd1, -5);
    cfg(1, 2'd3, 1);
    beat("rst_mode", 1, 70, 60, -5, 1'b1);

    cfg(2, 2'd0, 10);
    cfg(2, 2'd2, 2);
    beat("ref0", 2, 20, 0, 10, 1'b1);
    beat("ref1", 2, 50, 7, 7, 1'b0);
    beat("ref2", 2, 50, 7, 7, 1'b0);
    beat("ref3", 2, 50, 7, 47, 1'b1);
    cfg(2, 2'd2, 2);
    beat("ref_clr", 2, 50, 7, 47, 1'b1);

    cfg(4, 2'd0, 32'h7FFF_FFFF);
    beat("sat_pos", 4, 32'h7FFF_FFF0, 32'h20, 32'h7FFF_FFFF, 1'b0);
    beat("sat_neg", 4, 32'h8000_0000, -1, 32'h8000_0000, 1'b0);

    cfg(6, 2'd0, -2);
    beat("sat_sub", 6, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 1'b1);

    cfg(5, 2'd0, 100);
    cfg(5, 2'd3, 2);
    beat("clamp", 5, -10, 3, 0, 1'b0);
    beat("noclamp", 3, -10, 3, -7, 1'b0);

    beat("oor", 13, 5, 0, 5, 1'b0);

    // Backpressure: 8 beats to neurons 7/8 with out_ready low for cycles 4..8.
    cfg(7, 2'd0, 1000);
    cfg(8, 2'd0, 1000);
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 8 && cyc < 100) begin
      bus.out_ready    = !(cyc >= 4 && cyc < 9);
      bus.in_valid     = (sent < 8);
      bus.in_idx       = IDX_W'(7 + (sent % 2));
      bus.in_weight    = sent;
      bus.in_potential = 10 * sent;
      #1;
      if (cyc >= 4 && cyc < 9) chk("bp_in_ready", 64'(bus.in_ready), 64'(1'b0));
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_idx", 64'(bus.out_idx), 64'(7 + (got % 2)));
        chk("bp_pot", bus.out_potential, 64'(11 * got));
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) sent++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_count", 64'(got), 64'(8));
    chk("bp_cycles", 64'(cyc), 64'(15));
    tick();
    chk("bp_no_dup", 64'(bus.out_valid), 64'(1'b0));

    // Async reset with two beats in flight.
    bus.in_valid     = 1'b1;
    bus.in_idx       = 3;
    bus.in_weight    = 5;
    bus.in_potential = 5;
    tick();
    bus.in_idx       = 4;
    bus.in_weight    = 6;
    bus.in_potential = 6;
    tick();
    bus.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("arst_out_pot", bus.out_potential, 64'(0));
    chk("arst_out_idx", 64'(bus.out_idx), 64'(0));
    chk("arst_out_spike", 64'(bus.out_spike), 64'(1'b0));
    tick();
    #3 rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.out_valid) stray++;
    end
    chk("arst_no_stray", 64'(stray), 64'(0));
    beat("arst_thr0", 3, 1, 0, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
